fmap_pixel_streamer: RTL and testbench
======================================

// Module: fmap_pixel_streamer
// PURPOSE
//  Source end of the raster pixel stream consumed by the 3x3 conv engine.
//  - On start, reads one COL_NUM x ROW_NUM INT8 feature map from a sync RAM.
//  - Emits it row-major on dout/valid_out, with optional PAD-wide zero border.
//  - Honours downstream ready; flags frame/line boundaries; pulses done at frame end.
// PARAMETERS
//  WIDTH    8    pixel width (signed INT8)
//  COL_NUM  128  stored map columns
//  ROW_NUM  128  stored map rows
//  PAD      0    zero-border width on each side, 0 or 1
//  ADDR_W   14   RAM address width, >= clog2(COL_NUM*ROW_NUM)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous reset, active-high
//  start      in   1       start one frame; sampled in IDLE only
//  busy       out  1       high from accepted start until done
//  done       out  1       1-cycle pulse after last pixel handshake
//  rd_en      out  1       RAM read strobe
//  rd_addr    out  ADDR_W  RAM address = (r-PAD)*COL_NUM + (c-PAD)
//  rd_data    in   WIDTH   RAM data, valid 1 cycle after rd_en; held while rd_en=0
//  ready      in   1       downstream accepts dout this cycle
//  valid_out  out  1       dout valid
//  dout       out  WIDTH   pixel, signed
//  sof        out  1       with first pixel of frame
//  eol        out  1       with last pixel of each output row
//  eof        out  1       with last pixel of frame
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in IDLE; counters 0; nothing in flight.
//  - Output frame size: OC = COL_NUM+2*PAD columns, OR = ROW_NUM+2*PAD rows.
//  - FSM:
//    - IDLE --start--> RUN.
//    - RUN: issues positions (c,r); after (OC-1,OR-1) is issued -> DRAIN.
//    - DRAIN: waits for last-pixel handshake -> DONE.
//    - DONE: lasts 1 cycle, done=1 -> IDLE.
//  - start while not IDLE is ignored.
//  - adv = ready | ~valid_out. All pipeline state moves only when adv=1.
//  - Issue cycle (RUN, adv=1):
//    - Interior position: rd_en=1 with its address.
//    - Pad position (c<PAD, c>=OC-PAD, r<PAD, r>=OR-PAD): rd_en=0; tagged pad.
//    - Counter c wraps OC-1 -> 0 and increments r.
//  - Stage 1 (registered): s1_valid, s1_pad, s1_sof, s1_eol, s1_eof.
//  - Output register (on adv):
//    - valid_out <= s1_valid; dout <= s1_pad ? 0 : rd_data; sof/eol/eof follow.
//  - Latency: start sampled at edge E0 -> rd_en in cycle after E0
//    -> valid_out=1 after E2.
//  - Throughput: 1 pixel/clk with ready held high.
//  - Backpressure:
//    - valid_out=1 and ready=0: dout, valid_out and flags stable; rd_en=0;
//      counters and stage 1 frozen.
//    - Resumes on the first cycle with ready=1, with no pixel lost or duplicated.
//  - done pulses in the cycle after the eof handshake; busy drops in that same cycle.
//  - rst mid-frame: immediate return to reset state; no rd_en afterwards;
//    the partial frame is abandoned.
//  - Back-to-back: start in the cycle done=1 is ignored (FSM not IDLE);
//    earliest restart is the next cycle.
// STRUCTURE
//  - Shared header cnn_defines.vh: INT8 WIDTH, FSM state encodings, default map dims.
//  - One sub-module: fmap_raster_cnt. Col/row counter with enable.
//    - Outputs c, r, last_col, last_pix, is_pad.
//    - Reused by the conv-side line counters.
//  - Top: FSM, address multiply-free generation, stage 1, output register.
//    - Address generation uses a running address register: +1 per interior pixel.
// TESTING
//  - PAD=0, 4x3 map, RAM[i]=i, ready=1:
//    dout 0..11 on 12 consecutive cycles; eol on 3,7,11; sof on 0; eof on 11;
//    done 1 cycle later.
//  - PAD=1, 4x3 map, RAM[i]=i+1: 6x5 = 30 pixels.
//    - Row 0 all 0.
//    - Row 1 = 0,1,2,3,4,0.
//    - Row 4 all 0.
//    - 12 rd_en pulses total.
//  - ready pattern 1,0,0,1,0,1... on the PAD=0 4x3 map: accepted sequence still 0..11.
//    dout stable while ready=0; no rd_en while stalled.
//  - start pulsed at pixel 5 of the PAD=0 4x3 map: ignored.
//    Exactly 12 pixels, one done pulse.
//  - rst asserted at pixel 6: all outputs 0 next cycle, no further rd_en.
//    A new start then yields a full frame beginning 0.
//  - Two frames, second start in the cycle after done:
//    frame gap = 1 idle cycle + 2-cycle latency; both frames 0..11.

Source files
------------

// File: rtl/fmap_pixel_streamer_pkg.sv
// Shared definitions for the feature-map pixel streamer: pixel width, FSM encoding,
// default map dimensions and a counter-width helper.
package fmap_pixel_streamer_pkg;

  localparam int INT8_W      = 8;
  localparam int DEF_COL_NUM = 128;
  localparam int DEF_ROW_NUM = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Counter width that stays >= 1 for degenerate single-entry dimensions.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmap_pixel_streamer_raster_cnt.sv
// Column/row raster counter over an output frame (pad border included).
// Also used by the conv-side line counters.
module fmap_raster_cnt
  import fmap_pixel_streamer_pkg::*;
#(
  parameter int COLS = 4,
  parameter int ROWS = 3,
  parameter int PAD  = 0,
  localparam int CW  = cnt_w(COLS),
  localparam int RW  = cnt_w(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] c,
  output logic [RW-1:0] r,
  output logic          last_col,
  output logic          last_pix,
  output logic          is_pad
);

  assign last_col = (c == CW'(COLS - 1));
  assign last_pix = last_col && (r == RW'(ROWS - 1));

  generate
    if (PAD > 0) begin : g_pad
      assign is_pad = (c < CW'(PAD)) || (c >= CW'(COLS - PAD)) ||
                      (r < RW'(PAD)) || (r >= RW'(ROWS - PAD));
    end else begin : g_nopad
      assign is_pad = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c <= '0;
      r <= '0;
    end else if (en) begin
      if (last_col) begin
        c <= '0;
        r <= last_pix ? '0 : r + RW'(1);
      end else begin
        c <= c + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fmap_pixel_streamer.sv
// Streams one stored INT8 feature map out of a sync RAM in raster order, optionally
// wrapped in a zero border, with ready/valid backpressure and frame/line flags.
module fmap_pixel_streamer
  import fmap_pixel_streamer_pkg::*;
#(
  parameter int WIDTH   = INT8_W,
  parameter int COL_NUM = DEF_COL_NUM,
  parameter int ROW_NUM = DEF_ROW_NUM,
  parameter int PAD     = 0,
  parameter int ADDR_W  = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic signed [WIDTH-1:0] rd_data,
  input  logic                    ready,
  output logic                    valid_out,
  output logic signed [WIDTH-1:0] dout,
  output logic                    sof,
  output logic                    eol,
  output logic                    eof
);

  localparam int OUT_COLS = COL_NUM + 2 * PAD;
  localparam int OUT_ROWS = ROW_NUM + 2 * PAD;
  localparam int CW       = cnt_w(OUT_COLS);
  localparam int RW       = cnt_w(OUT_ROWS);

  state_t state, state_nxt;

  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic          last_col, last_pix, is_pad;
  logic          adv, issue;
  logic          s1_valid, s1_pad, s1_sof, s1_eol, s1_eof;

  // Everything downstream of the counters advances together, so a stall freezes
  // the whole pipe and the RAM holds its last read data.
  assign adv   = ready | ~valid_out;
  assign issue = (state == ST_RUN) && adv;
  assign rd_en = issue && !is_pad;
  assign busy  = (state == ST_RUN) || (state == ST_DRAIN);
  assign done  = (state == ST_DONE);

  fmap_raster_cnt #(
    .COLS (OUT_COLS),
    .ROWS (OUT_ROWS),
    .PAD  (PAD)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (issue),
    .c        (c),
    .r        (r),
    .last_col (last_col),
    .last_pix (last_pix),
    .is_pad   (is_pad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (issue && last_pix) state_nxt = ST_DRAIN;
      ST_DRAIN: if (valid_out && ready && eof) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
    endcase
  end

  // Running address: interior pixels are read in storage order, so +1 per read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  rd_addr <= '0;
    else if (state == ST_IDLE) rd_addr <= '0;
    else if (rd_en)           rd_addr <= rd_addr + ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pad   <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
    end else if (adv) begin
      s1_valid <= issue;
      s1_pad   <= is_pad;
      s1_sof   <= issue && (c == '0) && (r == '0);
      s1_eol   <= issue && last_col;
      s1_eof   <= issue && last_pix;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      dout      <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
    end else if (adv) begin
      valid_out <= s1_valid;
      dout      <= s1_pad ? '0 : rd_data;
      sof       <= s1_valid && s1_sof;
      eol       <= s1_valid && s1_eol;
      eof       <= s1_valid && s1_eof;
    end
  end

endmodule

// File: tb/tb_fmap_pixel_streamer.sv
// Directed bench: a 4x3 map without border (RAM[i]=i) and with a 1-pixel border
// (RAM[i]=i+1), covering backpressure, ignored starts, mid-frame reset and restart.
module tb_fmap_pixel_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start0, start1, ready0, ready1;
  logic busy0, done0, rd_en0, valid0, sof0, eol0, eof0;
  logic busy1, done1, rd_en1, valid1, sof1, eol1, eof1;
  logic [13:0] rd_addr0, rd_addr1;
  logic signed [7:0] rd_data0, rd_data1, dout0, dout1;

  fmap_pixel_streamer #(.WIDTH(8), .COL_NUM(4), .ROW_NUM(3), .PAD(0), .ADDR_W(14)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0), .ready(ready0),
    .valid_out(valid0), .dout(dout0), .sof(sof0), .eol(eol0), .eof(eof0));

  fmap_pixel_streamer #(.WIDTH(8), .COL_NUM(4), .ROW_NUM(3), .PAD(1), .ADDR_W(14)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1), .ready(ready1),
    .valid_out(valid1), .dout(dout1), .sof(sof1), .eol(eol1), .eof(eof1));

  // Sync RAM models: data one cycle after rd_en, held otherwise.
  always @(posedge clk) begin
    if (rd_en0) rd_data0 <= rd_addr0[7:0];
    if (rd_en1) rd_data1 <= rd_addr1[7:0] + 8'd1;
  end

  int passed = 0;
  int total  = 0;

  int px_q[$];
  longint unsigned sof_m, eol_m, eof_m;
  int first_v, done_idx, done_cnt, rd_cnt, stall_bad, busy_first;

  function automatic int get_px(input int i);
    return (i < px_q.size()) ? px_q[i] : -999;
  endfunction

  // Drives one frame on DUT sel and records what it observes; no checking here.
  task automatic run_frame(input int sel, input int rmode, input int start_at,
                           input int stop_at, input bit do_start);
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bit fired = 1'b0, prev_stall = 1'b0;
    logic v, rdy, so, eo, ef, dn, re, bz;
    logic signed [7:0] d, prev_d;
    px_q.delete();
    sof_m = 0; eol_m = 0; eof_m = 0;
    first_v = -1; done_idx = -1; done_cnt = 0; rd_cnt = 0; stall_bad = 0; busy_first = -1;
    prev_d = '0;
    if (do_start) begin
      @(negedge clk);
      if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    end
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      rdy = (rmode == 0) ? 1'b1 : pat[k % 6];
      if (sel == 0) begin start0 = 1'b0; ready0 = rdy; end
      else          begin start1 = 1'b0; ready1 = rdy; end
      if (start_at >= 0 && !fired && px_q.size() == start_at) begin
        fired = 1'b1;
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
      end
      #1;
      if (sel == 0) begin
        v = valid0; d = dout0; so = sof0; eo = eol0; ef = eof0; dn = done0; re = rd_en0; bz = busy0;
      end else begin
        v = valid1; d = dout1; so = sof1; eo = eol1; ef = eof1; dn = done1; re = rd_en1; bz = busy1;
      end
      if (k == 0) busy_first = int'(bz);
      if (re) rd_cnt++;
      if (prev_stall && (!v || d !== prev_d)) stall_bad++;
      if (v && !rdy && re) stall_bad++;
      prev_stall = v && !rdy;
      prev_d = d;
      if (v && first_v < 0) first_v = k;
      if (v && rdy) begin
        if (so) sof_m |= (64'd1 << px_q.size());
        if (eo) eol_m |= (64'd1 << px_q.size());
        if (ef) eof_m |= (64'd1 << px_q.size());
        px_q.push_back(int'(d));
      end
      if (dn) begin
        done_cnt++;
        if (done_idx < 0) done_idx = k;
        break;
      end
      if (stop_at >= 0 && px_q.size() == stop_at) break;
    end
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; ready0 = 1'b1; ready1 = 1'b1;
    @(negedge clk); #1;
    total++;
    if ({valid0, sof0, eol0, eof0, busy0, done0, rd_en0} !== 7'd0)
      $display("FAIL reset_flags0: got %b want 0", {valid0, sof0, eol0, eof0, busy0, done0, rd_en0});
    else passed++;
    total++;
    if (dout0 !== 8'sd0 || rd_addr0 !== 14'd0)
      $display("FAIL reset_data0: dout %0d addr %0d want 0 0", dout0, rd_addr0);
    else passed++;
    total++;
    if ({valid1, sof1, eol1, eof1, busy1, done1, rd_en1} !== 7'd0)
      $display("FAIL reset_flags1: got %b want 0", {valid1, sof1, eol1, eof1, busy1, done1, rd_en1});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_frame(0, 0, -1, -1, 1'b1);
    total++;
    if (busy_first !== 1) $display("FAIL basic_busy: got %0d want 1", busy_first); else passed++;
    total++;
    if (first_v !== 2) $display("FAIL basic_latency: got %0d want 2", first_v); else passed++;
    total++;
    if (px_q.size() !== 12) $display("FAIL basic_count: got %0d want 12", px_q.size()); else passed++;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (get_px(i) !== i) $display("FAIL basic_px%0d: got %0d want %0d", i, get_px(i), i);
      else passed++;
    end
    total++;
    if (sof_m !== 64'h1 || eol_m !== 64'h888 || eof_m !== 64'h800)
      $display("FAIL basic_flags: sof %h eol %h eof %h want 1 888 800", sof_m, eol_m, eof_m);
    else passed++;
    total++;
    if (done_idx !== 14) $display("FAIL basic_done: got %0d want 14", done_idx); else passed++;
    total++;
    if (rd_cnt !== 12) $display("FAIL basic_rd: got %0d want 12", rd_cnt); else passed++;
    total++;
    if (busy0 !== 1'b0) $display("FAIL basic_busy_at_done: got %b want 0", busy0); else passed++;
  endtask

  task automatic test_pad();
    int exp1[30] = '{0, 0, 0, 0, 0, 0,
                     0, 1, 2, 3, 4, 0,
                     0, 5, 6, 7, 8, 0,
                     0, 9, 10, 11, 12, 0,
                     0, 0, 0, 0, 0, 0};
    run_frame(1, 0, -1, -1, 1'b1);
    total++;
    if (px_q.size() !== 30) $display("FAIL pad_count: got %0d want 30", px_q.size()); else passed++;
    for (int i = 0; i < 30; i++) begin
      total++;
      if (get_px(i) !== exp1[i]) $display("FAIL pad_px%0d: got %0d want %0d", i, get_px(i), exp1[i]);
      else passed++;
    end
    total++;
    if (rd_cnt !== 12) $display("FAIL pad_rd: got %0d want 12", rd_cnt); else passed++;
    total++;
    if (sof_m !== 64'h1 || eol_m !== 64'h20820820 || eof_m !== 64'h20000000)
      $display("FAIL pad_flags: sof %h eol %h eof %h want 1 20820820 20000000", sof_m, eol_m, eof_m);
    else passed++;
    total++;
    if (done_idx !== 32) $display("FAIL pad_done: got %0d want 32", done_idx); else passed++;
  endtask

  task automatic test_backpressure();
    run_frame(0, 1, -1, -1, 1'b1);
    total++;
    if (px_q.size() !== 12) $display("FAIL bp_count: got %0d want 12", px_q.size()); else passed++;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (get_px(i) !== i) $display("FAIL bp_px%0d: got %0d want %0d", i, get_px(i), i);
      else passed++;
    end
    total++;
    if (stall_bad !== 0) $display("FAIL bp_stall: got %0d violations want 0", stall_bad); else passed++;
    total++;
    if (rd_cnt !== 12 || done_cnt !== 1)
      $display("FAIL bp_rd_done: rd %0d done %0d want 12 1", rd_cnt, done_cnt);
    else passed++;
    total++;
    if (eol_m !== 64'h888 || eof_m !== 64'h800)
      $display("FAIL bp_flags: eol %h eof %h want 888 800", eol_m, eof_m);
    else passed++;
  endtask

  task automatic test_restart_ignored();
    run_frame(0, 0, 5, -1, 1'b1);
    total++;
    if (px_q.size() !== 12 || done_cnt !== 1)
      $display("FAIL restart_count: px %0d done %0d want 12 1", px_q.size(), done_cnt);
    else passed++;
    total++;
    if (get_px(0) !== 0 || get_px(11) !== 11)
      $display("FAIL restart_ends: first %0d last %0d want 0 11", get_px(0), get_px(11));
    else passed++;
    @(negedge clk); #1;
    total++;
    if (busy0 !== 1'b0 || rd_en0 !== 1'b0)
      $display("FAIL restart_idle: busy %b rd_en %b want 0 0", busy0, rd_en0);
    else passed++;
  endtask

  task automatic test_rst_mid();
    int bad = 0;
    run_frame(0, 0, -1, 6, 1'b1);
    rst = 1'b1;
    #1;
    total++;
    if ({valid0, sof0, eol0, eof0, busy0, done0, rd_en0} !== 7'd0 || dout0 !== 8'sd0)
      $display("FAIL rst_mid_now: flags %b dout %0d want 0 0",
               {valid0, sof0, eol0, eof0, busy0, done0, rd_en0}, dout0);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({valid0, sof0, eol0, eof0, busy0, done0, rd_en0} !== 7'd0 || dout0 !== 8'sd0)
      $display("FAIL rst_mid_next: flags %b dout %0d want 0 0",
               {valid0, sof0, eol0, eof0, busy0, done0, rd_en0}, dout0);
    else passed++;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      if (rd_en0 || valid0) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL rst_mid_quiet: got %0d active cycles want 0", bad); else passed++;
    run_frame(0, 0, -1, -1, 1'b1);
    total++;
    if (px_q.size() !== 12 || first_v !== 2)
      $display("FAIL rst_mid_refr: px %0d lat %0d want 12 2", px_q.size(), first_v);
    else passed++;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (get_px(i) !== i) $display("FAIL rst_mid_px%0d: got %0d want %0d", i, get_px(i), i);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    run_frame(0, 0, -1, -1, 1'b1);
    total++;
    if (px_q.size() !== 12 || done0 !== 1'b1)
      $display("FAIL b2b_f1: px %0d done %b want 12 1", px_q.size(), done0);
    else passed++;
    start0 = 1'b1;               // lands in the done cycle: must be ignored
    @(negedge clk); #1;
    total++;
    if (busy0 !== 1'b0) $display("FAIL b2b_ignored: busy %b want 0", busy0); else passed++;
    run_frame(0, 0, -1, -1, 1'b0);
    total++;
    if (first_v !== 2 || done_idx !== 14)
      $display("FAIL b2b_f2_timing: lat %0d done %0d want 2 14", first_v, done_idx);
    else passed++;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (get_px(i) !== i) $display("FAIL b2b_px%0d: got %0d want %0d", i, get_px(i), i);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad();
    test_backpressure();
    test_restart_ignored();
    test_rst_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
